// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pkg : shared types and defaults for the SPI responder       rev 1.0
// ---------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } spi_state_t;

  localparam int         DEF_DATA_W    = 8;
  localparam logic [7:0] DEF_FILL_WORD = 8'hFF;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_sync_edge : N-stage synchronizer with rise/fall strobes      rev 1.0
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_responder : SPI mode-0 responder with rx/tx valid-ready ports rev 1.0
// ---------------------------------------------------------------------------
module spi_responder
  import spi_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL_WORD   = DATA_W'(DEF_FILL_WORD)
) (
  input  logic              sys_clk_i,
  input  logic              cpu_rst_i,
  input  logic              spi_sck_i,
  input  logic              spi_mosi_i,
  input  logic              spi_cs_n_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
  input  logic              overrun_clr_i,
  output logic              busy_o
);

  localparam int                CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic w_sck_rise, w_sck_fall, w_mosi, w_cs_n;
  logic sck_level_unused;
  logic [1:0] cs_edge_unused, mosi_edge_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(sys_clk_i), .rst_i(cpu_rst_i), .d_i(spi_sck_i),
    .q_o(sck_level_unused), .rise_o(w_sck_rise), .fall_o(w_sck_fall));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i(sys_clk_i), .rst_i(cpu_rst_i), .d_i(spi_cs_n_i),
    .q_o(w_cs_n), .rise_o(cs_edge_unused[0]), .fall_o(cs_edge_unused[1]));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(sys_clk_i), .rst_i(cpu_rst_i), .d_i(spi_mosi_i),
    .q_o(w_mosi), .rise_o(mosi_edge_unused[0]), .fall_o(mosi_edge_unused[1]));

  spi_state_t        state_q, state_d;
  logic [SYNC_STAGES-1:0] settle_q, settle_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              boundary_q, boundary_d;
  logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;

  logic              w_load, w_word_done;
  logic [DATA_W-1:0] w_word;

  always_ff @(posedge sys_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      bitcnt_q    <= '0;
      boundary_q  <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      bitcnt_q    <= bitcnt_d;
      boundary_q  <= boundary_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    // cs_n synchronizer resets high; wait until it has flushed before arming
    settle_d    = {settle_q[SYNC_STAGES-2:0], 1'b1};
    bitcnt_d    = bitcnt_q;
    boundary_d  = boundary_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    w_load      = 1'b0;
    w_word_done = 1'b0;
    w_word      = {rx_shift_q, w_mosi};

    case (state_q)
      IDLE: begin
        if (settle_q[SYNC_STAGES-1] && w_cs_n) state_d = ARMED;
      end
      ARMED: begin
        if (!w_cs_n) begin
          state_d    = ACTIVE;
          w_load     = 1'b1;
          bitcnt_d   = '0;
          boundary_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (w_cs_n) begin
          state_d    = ARMED;
          bitcnt_d   = '0;
          boundary_d = 1'b0;
        end else if (w_sck_rise) begin
          rx_shift_d = w_word[DATA_W-2:0];
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d    = '0;
            boundary_d  = 1'b1;
            w_word_done = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end else if (w_sck_fall) begin
          if (boundary_q) begin
            w_load     = 1'b1;
            boundary_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load drains the old holding word; a write only lands if it was empty
    if (w_load) begin
      tx_shift_d  = hold_full_q ? hold_q : FILL_WORD;
      hold_full_d = 1'b0;
    end
    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (overrun_clr_i) overrun_d = 1'b0;
    if (w_word_done) begin
      if (!rx_valid_q || rx_ready_i) begin
        rx_data_d  = w_word;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign busy_o        = (state_q == ACTIVE);
  assign spi_miso_oe_o = (state_q == ACTIVE);
  assign spi_miso_o    = (state_q == ACTIVE) & tx_shift_q[DATA_W-1];
  assign tx_ready_o    = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = overrun_q;

endmodule
`default_nettype wire
